// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage feeding decode. Owns the program counter, drives the address of
// a combinational, byte-addressed instruction ROM, and captures one word per
// cycle into a small FIFO. Decode consumes the FIFO head with a valid/ready
// handshake. A redirect flushes the queue and restarts fetch at a new PC. An
// illegal fetch address (misaligned or outside the ROM window) enqueues a
// single fault entry carrying a NOP (0x00000013). Fetch then stops until the
// next redirect.
//
// Ports
//   clk             in   1    clock, rising edge
//   rst_n           in   1    asynchronous reset, active low
//   rom_addr        out  AW   byte address to ROM (always pc_q)
//   rom_dout        in   DW   instruction word returned by ROM this cycle
//   redirect_valid  in   1    flush queue, restart fetch at redirect_pc
//   redirect_pc     in   AW   new fetch address
//   out_valid       out  1    head entry valid
//   out_ready       in   1    decode accepts the head entry
//   out_instr       out  DW   head instruction
//   out_pc          out  AW   PC of head instruction
//   out_fault       out  1    head entry is a fetch fault
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'hBFC00000,
    parameter logic [ADDRESS_WIDTH-1:0]   ROM_BASE      = 32'hBFC00000,
    parameter logic [ADDRESS_WIDTH-1:0]   ROM_LIMIT     = 32'hBFC00FFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ADDRESS_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_dout,
    input  logic                      redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]  redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_instr,
    output logic [ADDRESS_WIDTH-1:0]  out_pc,
    output logic                      out_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]         DEPTH_C    = CNT_W'(DEPTH);
    // The highest address at which a full 32-bit word still fits in the ROM.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_FETCH = ROM_LIMIT - ADDRESS_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0]    NOP_INSTR  = DATA_WIDTH'(32'h00000013);

    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_FAULT = 1'b1;

    typedef struct packed {
        logic                     fault;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] pc_q,     pc_d;
    logic [0:0]               state_q,  state_d;
    logic [CNT_W-1:0]         count_q,  count_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    entry_t                   fifo_q [DEPTH];
    entry_t                   fifo_d [DEPTH];

    logic   pop;
    logic   space;
    logic   bad;
    logic   push;
    entry_t wr_entry;

    assign rom_addr  = pc_q;
    assign out_valid = (count_q != '0);
    // The head is read straight from storage, so a word written at an edge is
    // visible right after that edge without a bypass from rom_dout.
    assign out_instr = fifo_q[rd_ptr_q].instr;
    assign out_pc    = fifo_q[rd_ptr_q].pc;
    assign out_fault = fifo_q[rd_ptr_q].fault;

    always_comb begin
        pop   = out_valid & out_ready;
        // A pop frees a slot in the same cycle, so a full queue still streams.
        space = (count_q < DEPTH_C) | pop;
        bad   = (pc_q[1:0] != 2'b00) | (pc_q < ROM_BASE) | (pc_q > LAST_FETCH);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        pc_d     = pc_q;
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fifo_d   = fifo_q;
        push     = 1'b0;
        wr_entry = '0;

        if (redirect_valid) begin
            // Redirect wins over enqueue and pop. Any pop this cycle is
            // discarded along with the rest of the queue.
            pc_d     = redirect_pc;
            state_d  = STATE_RUN;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if ((state_q == STATE_RUN) && space) begin
                push = 1'b1;
                if (bad) begin
                    wr_entry = '{fault: 1'b1, pc: pc_q, instr: NOP_INSTR};
                    state_d  = STATE_FAULT;
                end else begin
                    wr_entry = '{fault: 1'b0, pc: pc_q, instr: rom_dout};
                    pc_d     = pc_q + ADDRESS_WIDTH'(4);
                end
            end

            if (push) begin
                fifo_d[wr_ptr_q] = wr_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            state_q  <= STATE_RUN;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            // NOTE: the storage is reset, unlike a typical RAM. The head
            // outputs read it directly and must be zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue. A combinational ROM model returns a
// word derived from the address. Inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= 32'hBFC00000 && a <= 32'hBFC00FFF)
            return a ^ 32'h5A5A0000;
        return 32'hDEADBEEF;
    endfunction

    assign rom_dout = rom_word(rom_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock: through the rising edge, back to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic fault);
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " pc"},    out_pc,    pc);
        check({tag, " fault"}, out_fault, fault);
        check({tag, " instr"}, out_instr, fault ? 32'h00000013 : rom_word(pc));
    endtask

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        tick();

        // Reset state
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_fault", out_fault, 1'b0);
        check("rst out_instr", out_instr, 32'h0);
        check("rst out_pc",    out_pc,    32'h0);
        check("rst rom_addr",  rom_addr,  32'hBFC00000);

        // 1. Streaming after reset release
        rst_n = 1'b1;
        tick();
        expect_head("t1 h0", 32'hBFC00000, 1'b0);
        tick();
        expect_head("t1 h1", 32'hBFC00004, 1'b0);
        tick();
        expect_head("t1 h2", 32'hBFC00008, 1'b0);

        // 2. Back-pressure fills the queue, then drains with no gaps
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check("t2 rom_addr stuck", rom_addr, 32'hBFC00010);
        expect_head("t2 held", 32'hBFC00000, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_head($sformatf("t2 drain%0d", i), 32'hBFC00000 + 32'(i * 4), 1'b0);
            tick();
        end

        // 3. Redirect with a pop while 3 entries are queued
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check("t3 rom_addr pre", rom_addr, 32'hBFC0000C);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00100;
        tick();
        redirect_valid = 1'b0;
        check("t3 flushed valid", out_valid, 1'b0);
        check("t3 rom_addr",      rom_addr,  32'hBFC00100);
        tick();
        expect_head("t3 h0", 32'hBFC00100, 1'b0);
        tick();
        expect_head("t3 h1", 32'hBFC00104, 1'b0);

        // 4. Last legal word, then a fault at the end of the window
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00FFC;
        tick();
        redirect_valid = 1'b0;
        check("t4 flushed valid", out_valid, 1'b0);
        tick();
        expect_head("t4 last", 32'hBFC00FFC, 1'b0);
        tick();
        expect_head("t4 fault", 32'hBFC01000, 1'b1);
        tick();
        check("t4 drained valid", out_valid, 1'b0);
        tick();
        tick();
        check("t4 still empty",  out_valid, 1'b0);
        check("t4 rom_addr held", rom_addr, 32'hBFC01000);

        // 5. Misaligned fault, then recovery via redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00002;
        tick();
        redirect_valid = 1'b0;
        tick();
        expect_head("t5 fault", 32'hBFC00002, 1'b1);
        tick();
        check("t5 empty",         out_valid, 1'b0);
        check("t5 rom_addr held", rom_addr,  32'hBFC00002);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00000;
        tick();
        redirect_valid = 1'b0;
        tick();
        expect_head("t5 resume0", 32'hBFC00000, 1'b0);
        tick();
        expect_head("t5 resume1", 32'hBFC00004, 1'b0);

        // 6. Asynchronous reset between edges
        tick();
        check("t6 pre valid", out_valid, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async valid",    out_valid, 1'b0);
        check("t6 async rom_addr", rom_addr,  32'hBFC00000);
        check("t6 async out_pc",   out_pc,    32'h0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        expect_head("t6 h0", 32'hBFC00000, 1'b0);
        tick();
        expect_head("t6 h1", 32'hBFC00004, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
